// File: rtl/dutb_ctrl_pkg.sv
// Shared types for the dutb run controller.
package dutb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

endpackage

// File: rtl/dutb_param_pkg.sv
// Default sizing for the dutb run controller; the top module takes these as
// parameter defaults so a bench can override them per instance.
package dutb_param_pkg;

  localparam int P_RUN_CNT_W       = 16;
  localparam int P_MAX_FAIL_NUM    = 16;
  localparam int P_DUT_RST_CYCLES  = 4;
  localparam int P_MAX_OUTSTANDING = 4;
  localparam int P_DRAIN_TIMEOUT   = 1024;

endpackage

// File: rtl/dutb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dutb_sat_cnt #(
  parameter int P_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_inc,
  output logic [P_W-1:0] o_cnt
);

  logic [P_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dutb_run_ctrl.sv
// Test-run controller: DUT reset, req/ack transaction issue, pass/fail tally,
// fail-limit abort. Define DUTB_RUN_CTRL_DRAIN_TIMEOUT_EN for a DRAIN timeout.
module dutb_run_ctrl
  import dutb_ctrl_pkg::*;
#(
  parameter int P_CNT_W           = dutb_param_pkg::P_RUN_CNT_W,
  parameter int P_MAX_FAIL_NUM    = dutb_param_pkg::P_MAX_FAIL_NUM,
  parameter int P_DUT_RST_CYCLES  = dutb_param_pkg::P_DUT_RST_CYCLES,
  parameter int P_MAX_OUTSTANDING = dutb_param_pkg::P_MAX_OUTSTANDING,
  parameter int P_DRAIN_TIMEOUT   = dutb_param_pkg::P_DRAIN_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_CNT_W-1:0] num_txn,
  output logic               dut_rst_n,
  output logic               drv_req,
  input  logic               drv_ack,
  input  logic               res_valid,
  input  logic               res_pass,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               timeout,
  output logic               proto_err,
  output logic [P_CNT_W-1:0] txn_cnt,
  output logic [P_CNT_W-1:0] pass_cnt,
  output logic [P_CNT_W-1:0] fail_cnt
);

  localparam int LP_OUT_W = $clog2(P_MAX_OUTSTANDING + 1);
  localparam int LP_RST_W = $clog2(P_DUT_RST_CYCLES + 1);
  localparam logic [LP_OUT_W-1:0] LP_MAX_OUT  = LP_OUT_W'(P_MAX_OUTSTANDING);
  localparam logic [P_CNT_W:0]    LP_MAX_FAIL = (P_CNT_W + 1)'(P_MAX_FAIL_NUM);

  run_state_t          r_state;
  logic [LP_RST_W-1:0] r_rst_cnt;
  logic [P_CNT_W-1:0]  r_num_txn;
  logic [LP_OUT_W-1:0] r_outst;
  logic                r_dut_rst_n;
  logic                r_drv_req;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                r_timeout;
  logic                r_proto_err;

  logic                w_start_ok;
  logic                w_abort;
  logic                w_active;
  logic                w_issue;
  logic                w_res_acc;
  logic                w_res_stray;
  logic                w_pass_inc;
  logic                w_fail_inc;
  logic                w_fail_nxt_hit;
  logic                w_req_ok;
  logic                w_txn_done;
  logic                w_drain_to;
  logic [LP_OUT_W-1:0] w_outst_nxt;
  logic [P_CNT_W:0]    w_txn_nxt;
  logic [P_CNT_W:0]    w_fail_nxt;
  logic [P_CNT_W-1:0]  w_txn_cnt;
  logic [P_CNT_W-1:0]  w_pass_cnt;
  logic [P_CNT_W-1:0]  w_fail_cnt;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_abort    = ({1'b0, w_fail_cnt} >= LP_MAX_FAIL);

  // Results are frozen out in the abort cycle so the tally stops at the limit.
  assign w_active    = ((r_state == RST) || (r_state == RUN) || (r_state == DRAIN)) && !w_abort;
  assign w_issue     = r_drv_req && drv_ack;
  assign w_res_acc   = res_valid && w_active && (r_outst != '0);
  assign w_res_stray = res_valid && w_active && (r_outst == '0);
  assign w_pass_inc  = w_res_acc && res_pass;
  assign w_fail_inc  = w_res_acc && !res_pass;

  assign w_outst_nxt = r_outst + LP_OUT_W'(w_issue) - LP_OUT_W'(w_res_acc);
  assign w_txn_nxt   = {1'b0, w_txn_cnt} + (P_CNT_W + 1)'(w_issue);
  assign w_fail_nxt  = {1'b0, w_fail_cnt} + (P_CNT_W + 1)'(w_fail_inc);

  // drv_req is registered, so its next value looks one issue/result ahead.
  assign w_fail_nxt_hit = (w_fail_nxt >= LP_MAX_FAIL);
  assign w_req_ok       = (w_txn_nxt < {1'b0, r_num_txn}) && (w_outst_nxt < LP_MAX_OUT) &&
                          !w_fail_nxt_hit;
  assign w_txn_done     = (w_txn_cnt == r_num_txn);

`ifdef DUTB_RUN_CTRL_DRAIN_TIMEOUT_EN
  localparam int LP_TO_W = $clog2(P_DRAIN_TIMEOUT + 1);
  logic [LP_TO_W-1:0] r_drain_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  assign w_drain_to = (r_drain_cnt == LP_TO_W'(P_DRAIN_TIMEOUT - 1)) && (r_outst != '0);
`else
  assign w_drain_to = 1'b0;
`endif

  dutb_sat_cnt #(.P_W(P_CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_issue),
    .o_cnt (w_txn_cnt)
  );

  dutb_sat_cnt #(.P_W(P_CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_pass_inc),
    .o_cnt (w_pass_cnt)
  );

  dutb_sat_cnt #(.P_W(P_CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_ok),
    .i_inc (w_fail_inc),
    .o_cnt (w_fail_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_num_txn   <= '0;
      r_outst     <= '0;
      r_dut_rst_n <= 1'b0;
      r_drv_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_outst <= w_outst_nxt;
      if (w_res_stray) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state     <= RST;
            r_rst_cnt   <= LP_RST_W'(P_DUT_RST_CYCLES - 1);
            r_num_txn   <= num_txn;
            r_outst     <= '0;
            r_dut_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
          end
        end
        RST: begin
          if (r_rst_cnt == '0) begin
            r_state     <= RUN;
            r_dut_rst_n <= 1'b1;
            r_drv_req   <= w_req_ok;
          end else begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state   <= DONE;
            r_drv_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_txn_done) begin
            r_state   <= DRAIN;
            r_drv_req <= 1'b0;
          end else begin
            r_drv_req <= w_req_ok;
          end
        end
        DRAIN: begin
          if (w_abort || (r_outst == '0) || w_drain_to) begin
            r_state   <= DONE;
            r_drv_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= w_abort;
            r_timeout <= !w_abort && (r_outst != '0) && w_drain_to;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_drv_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign dut_rst_n = r_dut_rst_n;
  assign drv_req   = r_drv_req;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign timeout   = r_timeout;
  assign proto_err = r_proto_err;
  assign txn_cnt   = w_txn_cnt;
  assign pass_cnt  = w_pass_cnt;
  assign fail_cnt  = w_fail_cnt;

endmodule

// File: tb/tb_dutb_run_ctrl.sv
// Scoreboard bench for dutb_run_ctrl: a driver/checker model answers the DUT,
// final-status expectations are queued at start and checked on each done rise.
module tb_dutb_run_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_txn;
  logic             dut_rst_n;
  logic             drv_req;
  logic             drv_ack;
  logic             res_valid;
  logic             res_pass;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             timeout;
  logic             proto_err;
  logic [CNT_W-1:0] txn_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  typedef struct {
    string name;
    int    txn;
    int    pass;
    int    fail;
    int    ab;
    int    to;
    int    pe;
  } exp_t;

  typedef struct {
    int t;
    bit pass;
  } due_t;

  exp_t expQ[$];
  due_t dueQ[$];

  int nVec = 0;
  int nMis = 0;
  int cyc = 0;
  int resMode = 0;
  int injectReq = 0;
  int injectDone = 0;
  int dropReq = 0;
  int dropDone = 0;
  bit ackEn = 1'b1;
  bit prevDone = 1'b0;

  always #5 clk = ~clk;

  dutb_run_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_txn   (num_txn),
    .dut_rst_n (dut_rst_n),
    .drv_req   (drv_req),
    .drv_ack   (drv_ack),
    .res_valid (res_valid),
    .res_pass  (res_pass),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .timeout   (timeout),
    .proto_err (proto_err),
    .txn_cnt   (txn_cnt),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input string nm, input int t, input int p, input int f,
                                 input int a, input int to, input int pe);
    exp_t e;
    e.name = nm;
    e.txn  = t;
    e.pass = p;
    e.fail = f;
    e.ab   = a;
    e.to   = to;
    e.pe   = pe;
    return e;
  endfunction

  task automatic applyStimulus(input string name, input int n, input int mode,
                               input bit pushIt, input exp_t e);
    repeat (6) @(negedge clk);
    $display("[TB] starting run %s, num_txn=%0d", name, n);
    resMode = mode;
    num_txn = CNT_W'(n);
    start   = 1'b1;
    if (pushIt) expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxCyc);
    int n = 0;
    while (!done && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " done reached"}, int'(done), 1);
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, " dut_rst_n"}, int'(dut_rst_n), 0);
    checkOutput({tag, " drv_req"},   int'(drv_req), 0);
    checkOutput({tag, " busy"},      int'(busy), 0);
    checkOutput({tag, " done"},      int'(done), 0);
    checkOutput({tag, " aborted"},   int'(aborted), 0);
    checkOutput({tag, " timeout"},   int'(timeout), 0);
    checkOutput({tag, " proto_err"}, int'(proto_err), 0);
    checkOutput({tag, " txn_cnt"},   int'(txn_cnt), 0);
    checkOutput({tag, " pass_cnt"},  int'(pass_cnt), 0);
    checkOutput({tag, " fail_cnt"},  int'(fail_cnt), 0);
  endtask

  // Driver and checker model: ack always, results latency 3 after issue.
  initial begin
    due_t d;
    drv_ack   = 1'b0;
    res_valid = 1'b0;
    res_pass  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      res_valid = 1'b0;
      res_pass  = 1'b0;
      while (dueQ.size() > 0 && dueQ[0].t < cyc) void'(dueQ.pop_front());
      if (dueQ.size() > 0 && dueQ[0].t == cyc) begin
        d = dueQ.pop_front();
        res_valid = 1'b1;
        res_pass  = d.pass;
      end else if (injectDone < injectReq) begin
        injectDone++;
        res_valid = 1'b1;
        res_pass  = 1'b1;
      end
      drv_ack = ackEn;
      if (drv_req && drv_ack && resMode != 0) begin
        if (dropDone < dropReq) begin
          dropDone++;
        end else begin
          d.t    = cyc + 3;
          d.pass = (resMode == 1);
          dueQ.push_back(d);
        end
      end
    end
  end

  // Monitor: every rising done is matched against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", int'(done), 0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, " txn_cnt"},   int'(txn_cnt), e.txn);
          checkOutput({e.name, " pass_cnt"},  int'(pass_cnt), e.pass);
          checkOutput({e.name, " fail_cnt"},  int'(fail_cnt), e.fail);
          checkOutput({e.name, " aborted"},   int'(aborted), e.ab);
          checkOutput({e.name, " timeout"},   int'(timeout), e.to);
          checkOutput({e.name, " proto_err"}, int'(proto_err), e.pe);
          checkOutput({e.name, " busy"},      int'(busy), 0);
          checkOutput({e.name, " drv_req"},   int'(drv_req), 0);
          checkOutput({e.name, " dut_rst_n"}, int'(dut_rst_n), 1);
        end
      end
      prevDone = done;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    num_txn = '0;
    repeat (3) @(negedge clk);
    checkIdleReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run: reset hold length, then five passing transactions.
    applyStimulus("basic", 5, 1, 1'b1, mkExp("basic", 5, 5, 0, 0, 0, 0));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !dut_rst_n) n++;
      else break;
      @(negedge clk);
    end
    checkOutput("basic dut_rst_n low cycles", n, 4);
    checkOutput("basic dut_rst_n released", int'(dut_rst_n), 1);
    waitDone("basic", 100);

    // Silent checker: issue stalls at the outstanding limit.
    applyStimulus("outst", 20, 0, 1'b1, mkExp("outst", 20, 20, 0, 0, 0, 0));
    n = 0;
    while (int'(txn_cnt) < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checkOutput("outst limit txn_cnt", int'(txn_cnt), 4);
    checkOutput("outst limit drv_req", int'(drv_req), 0);
    checkOutput("outst limit busy", int'(busy), 1);
    resMode = 1;
    @(negedge clk);
    injectReq = injectReq + 4;
    waitDone("outst", 300);

    // All results fail: abort at 16 failures after 19 issues.
    applyStimulus("abort", 100, 2, 1'b1, mkExp("abort", 19, 0, 16, 1, 0, 0));
    n = 0;
    while (int'(fail_cnt) < 16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort cycle fail_cnt", int'(fail_cnt), 16);
    checkOutput("abort cycle drv_req", int'(drv_req), 0);
    checkOutput("abort cycle done", int'(done), 0);
    @(negedge clk);
    checkOutput("abort next done", int'(done), 1);
    checkOutput("abort next aborted", int'(aborted), 1);
    waitDone("abort", 10);

    // Stray result during RST, then overlapping issue/result traffic.
    applyStimulus("proto", 5, 1, 1'b1, mkExp("proto", 5, 5, 0, 0, 0, 1));
    injectReq = injectReq + 1;
    repeat (3) @(negedge clk);
    checkOutput("proto stray proto_err", int'(proto_err), 1);
    checkOutput("proto stray pass_cnt", int'(pass_cnt), 0);
    waitDone("proto", 100);

    // Reset in the middle of RUN, then a clean rerun.
    applyStimulus("midrst", 20, 1, 1'b0, mkExp("midrst", 0, 0, 0, 0, 0, 0));
    n = 0;
    while (int'(txn_cnt) < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst reached run", int'(txn_cnt) >= 6 ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    checkIdleReset("midrst async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus("rerun", 3, 1, 1'b1, mkExp("rerun", 3, 3, 0, 0, 0, 0));
    waitDone("rerun", 100);

    // One result never returns: drain timeout when enabled, otherwise stuck busy.
`ifdef DUTB_RUN_CTRL_DRAIN_TIMEOUT_EN
    applyStimulus("drain", 3, 1, 1'b1, mkExp("drain", 3, 2, 0, 0, 1, 0));
`else
    applyStimulus("drain", 3, 1, 1'b0, mkExp("drain", 3, 2, 0, 0, 1, 0));
`endif
    dropReq = dropReq + 1;
    n = 0;
    while (int'(txn_cnt) < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!done && n < 1200) begin
      @(negedge clk);
      n++;
    end
`ifdef DUTB_RUN_CTRL_DRAIN_TIMEOUT_EN
    checkOutput("drain cycles to done", n, 1025);
    checkOutput("drain timeout", int'(timeout), 1);
`else
    checkOutput("drain still busy", int'(busy), 1);
    checkOutput("drain no done", int'(done), 0);
    checkOutput("drain no timeout", int'(timeout), 0);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) @(negedge clk);
    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
